// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative shift-add multiplier.
package mul_pkg;

    // Default operand/product width.
    localparam int unsigned MUL_WIDTH = 32;

    // Iteration counter width: must be able to hold the value WIDTH itself.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

    localparam int unsigned MUL_CNT_WIDTH = cnt_width(MUL_WIDTH);

    // Controller states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mul_iter_unit.sv
// Iterative shift-add multiplier for MUL/MLA. Produces the low WIDTH bits of
// Rm*Rs, one multiplier bit per cycle, with a start/busy/done handshake so
// the pipeline can stall. The product register feeds the ALU Bin operand.
module mul_iter_unit
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH      = MUL_WIDTH,
    parameter bit          EARLY_TERM = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] Rm_in,
    input  logic [WIDTH-1:0] Rs_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Prod
);

    localparam int unsigned    CntW      = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastCount = CntW'(WIDTH);

    mul_state_e state_q, state_d;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] prod_q, prod_d;
    logic [CntW-1:0]  count_q, count_d;

    logic [WIDTH-1:0] acc_step;
    logic [WIDTH-1:0] mcand_step;
    logic [WIDTH-1:0] mplier_step;
    logic [CntW-1:0]  count_step;
    logic             last_iter;

    // One shift-add step and the termination test on the post-shift multiplier.
    always_comb begin
        acc_step    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mcand_step  = mcand_q << 1;
        mplier_step = mplier_q >> 1;
        count_step  = count_q + CntW'(1);
        // Early exit needs no leading-one detector: no set bits left means done.
        last_iter   = (count_step == LastCount) || (EARLY_TERM && (mplier_step == '0));
    end

    // Next-state and datapath load/update; flush overrides start and completion.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        prod_d   = prod_q;

        if (flush) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_d  = StRun;
                        acc_d    = '0;
                        mcand_d  = Rm_in;
                        mplier_d = Rs_in;
                        count_d  = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
                StRun: begin
                    acc_d    = acc_step;
                    mcand_d  = mcand_step;
                    mplier_d = mplier_step;
                    count_d  = count_step;
                    if (last_iter) begin
                        state_d = StDone;
                        prod_d  = acc_step;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State and datapath registers; reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            prod_q   <= prod_d;
        end
    end

    // Handshake outputs decode straight from state so reset clears them at once.
    always_comb begin
        busy = (state_q == StRun);
        done = (state_q == StDone);
        Prod = prod_q;
    end

endmodule

// File: tb/tb_mul_iter_unit.sv
// Scoreboard bench for mul_iter_unit: an early-terminating and a full-length
// instance share stimulus; each has its own queue of expected completions.
module tb_mul_iter_unit;

    typedef struct {
        int          s;     // edge that sampled start (first RUN period)
        int          d;     // period in which done must be high
        logic [31:0] prod;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [31:0] Rm_in;
    logic [31:0] Rs_in;
    logic        busy_v [2];
    logic        done_v [2];
    logic [31:0] prod_v [2];

    exp_t        sb [2][$];
    int          free_at [2];
    logic [31:0] last_prod [2];
    int          cyc;
    int          n_checks;
    int          n_fail;

    mul_iter_unit #(.WIDTH(32), .EARLY_TERM(1'b1)) u_dut_et (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .flush (flush),
        .Rm_in (Rm_in),
        .Rs_in (Rs_in),
        .busy  (busy_v[0]),
        .done  (done_v[0]),
        .Prod  (prod_v[0])
    );

    mul_iter_unit #(.WIDTH(32), .EARLY_TERM(1'b0)) u_dut_full (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .flush (flush),
        .Rm_in (Rm_in),
        .Rs_in (Rs_in),
        .busy  (busy_v[1]),
        .done  (done_v[1]),
        .Prod  (prod_v[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Iterations needed: position of the highest set multiplier bit, at least 1.
    function automatic int n_iter(input logic [31:0] rs, input bit et);
        int n;
        if (!et) return 32;
        n = 1;
        for (int b = 0; b < 32; b++) if (rs[b]) n = b + 1;
        return n;
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d period %0d: got %h, expected %h", name, i, cyc, act, exp);
        end
    endtask

    // Per-cycle monitor for one instance.
    task automatic check_dut(input int i);
        logic exp_busy;
        logic exp_done;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        while (sb[i].size() > 0 && sb[i][0].d < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL missing_done dut%0d: no done seen, expected in period %0d, now %0d",
                     i, sb[i][0].d, cyc);
            last_prod[i] = sb[i][0].prod;
            void'(sb[i].pop_front());
        end
        if (sb[i].size() > 0) begin
            exp_busy = (cyc >= sb[i][0].s) && (cyc < sb[i][0].d);
            exp_done = (cyc == sb[i][0].d);
        end
        chk("busy", i, {31'd0, busy_v[i]}, {31'd0, exp_busy});
        chk("done", i, {31'd0, done_v[i]}, {31'd0, exp_done});
        if (exp_done) begin
            last_prod[i] = sb[i][0].prod;
            void'(sb[i].pop_front());
        end
        chk("prod", i, prod_v[i], last_prod[i]);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) check_dut(i);
    end

    task automatic goto_period(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pulse start for one edge; each instance accepts only if not mid-multiply.
    task automatic issue(input logic [31:0] rm, input logic [31:0] rs, output int s);
        exp_t e;
        Rm_in = rm;
        Rs_in = rs;
        start = 1'b1;
        s = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (s > free_at[i]) begin
                e.s    = s;
                e.d    = s + n_iter(rs, (i == 0));
                e.prod = rm * rs;
                sb[i].push_back(e);
                free_at[i] = e.d;
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        Rm_in = $urandom;
        Rs_in = $urandom;
    endtask

    // Flush sampled at edge f cancels any completion at or after f.
    task automatic model_flush(input int f);
        for (int i = 0; i < 2; i++) begin
            while (sb[i].size() > 0 && sb[i][sb[i].size() - 1].d >= f) void'(sb[i].pop_back());
            free_at[i] = f;
        end
    endtask

    task automatic drain();
        int budget;
        budget = 200;
        while ((sb[0].size() > 0 || sb[1].size() > 0) && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        n_checks++;
        if (budget == 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d/%0d completions still pending, expected 0",
                     sb[0].size(), sb[1].size());
            sb[0].delete();
            sb[1].delete();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected normal finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          s;
        int          s2;
        logic [31:0] rm;
        logic [31:0] rs;

        clk = 1'b0;
        rst_n = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        Rm_in = '0;
        Rs_in = '0;
        cyc = 0;
        n_checks = 0;
        n_fail = 0;
        free_at[0] = 0;
        free_at[1] = 0;
        last_prod[0] = '0;
        last_prod[1] = '0;

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases.
        issue(32'd3, 32'd5, s);                     drain();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, s);     drain();
        issue(32'hFFFF_FFFF, 32'd1, s);             drain();
        issue(32'h1234_5678, 32'd0, s);             drain();
        issue(32'h8000_0000, 32'd2, s);             drain();

        // Back-to-back: second start during the early-term instance's done period.
        issue(32'd3, 32'd5, s);
        goto_period(s + 3);
        issue(32'd7, 32'd6, s2);
        drain();

        // Start while busy is ignored; flush aborts with Prod untouched.
        issue(32'd9, 32'hF0, s);
        goto_period(s + 1);
        issue($urandom, $urandom, s2);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        model_flush(cyc);
        drain();
        issue(32'd11, 32'd13, s);                   drain();

        // Asynchronous reset in the middle of a long multiply.
        issue(32'h0BAD_F00D, 32'hFFFF_FFFF, s);
        goto_period(s + 4);
        #2;
        rst_n = 1'b0;
        sb[0].delete();
        sb[1].delete();
        free_at[0] = 0;
        free_at[1] = 0;
        last_prod[0] = '0;
        last_prod[1] = '0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", i, {31'd0, busy_v[i]}, 32'd0);
            chk("rst_done", i, {31'd0, done_v[i]}, 32'd0);
            chk("rst_prod", i, prod_v[i], 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(32'd1234, 32'd5678, s);               drain();

        // Randomised operands, varied multiplier length, some back-to-back.
        for (int k = 0; k < 24; k++) begin
            rm = $urandom;
            rs = $urandom >> $urandom_range(0, 31);
            issue(rm, rs, s);
            if ($urandom_range(0, 1) == 1) begin
                goto_period(s + n_iter(rs, 1'b1));
                issue($urandom, $urandom >> $urandom_range(0, 31), s2);
            end
            drain();
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
